// File: rtl/digit_scan_pkg.sv
// Shared types and default constants for the multiplexed digit scanner.
// Macro DIGIT_SCAN_DEADTIME_EN adds the all-off GUARD state between digits.
package digit_scan_pkg;

  localparam int unsigned DefNDigits  = 4;
  localparam int unsigned DefDiv      = 50000;
  localparam int unsigned DefGuardCyc = 2;

`ifdef DIGIT_SCAN_DEADTIME_EN
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StGuard = 2'd2
  } scan_state_e;
`else
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1
  } scan_state_e;
`endif

endpackage

// File: rtl/onehot_n_dec.sv
// Index to active-low one-hot decoder; all-ones when disabled or index out of range.
module onehot_n_dec #(
  parameter int unsigned N = 4,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [W-1:0] i_idx,
  input  logic         i_en,
  output logic [N-1:0] o_an_n
);

  always_comb begin
    o_an_n = '1;
    if (i_en && (32'(i_idx) < N)) begin
      o_an_n[i_idx] = 1'b0;
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed digit scanner with registered active-low anode outputs.
// Define DIGIT_SCAN_DEADTIME_EN to insert GUARD_CYC all-off cycles between digits.
module digit_scan_ctrl
  import digit_scan_pkg::*;
#(
  parameter int unsigned N_DIGITS  = DefNDigits,
  parameter int unsigned DIV       = DefDiv,
  parameter int unsigned GUARD_CYC = DefGuardCyc,
  localparam int unsigned SEL_W    = $clog2(N_DIGITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [N_DIGITS-1:0] blank_mask,
  output logic [N_DIGITS-1:0] an,
  output logic [SEL_W-1:0]    sel,
  output logic                frame_start
);

  localparam int unsigned PRESC_W = $clog2(DIV);
  localparam logic [PRESC_W-1:0] PrescLast = PRESC_W'(DIV - 1);
  localparam logic [SEL_W-1:0] IdxLast = SEL_W'(N_DIGITS - 1);

  if (N_DIGITS < 2 || N_DIGITS > 16 || DIV < 2 || GUARD_CYC < 1) begin : g_param_check
    $error("digit_scan_ctrl: illegal parameter value");
  end

  scan_state_e         r_state, w_state_d;
  logic [SEL_W-1:0]    r_idx, w_idx_d, w_idx_next;
  logic [PRESC_W-1:0]  r_presc, w_presc_d;
  logic                w_frame_d;
  logic                w_drive_on;
  logic [N_DIGITS-1:0] w_an_d;
  logic [N_DIGITS-1:0] r_an;
  logic [SEL_W-1:0]    r_sel;
  logic                r_frame;

`ifdef DIGIT_SCAN_DEADTIME_EN
  localparam int unsigned GUARD_W = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam logic [GUARD_W-1:0] GuardLast = GUARD_W'(GUARD_CYC - 1);
  logic [GUARD_W-1:0] r_gcnt, w_gcnt_d;
`endif

  assign w_idx_next = (r_idx == IdxLast) ? '0 : r_idx + 1'b1;

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_presc_d = r_presc;
    w_frame_d = 1'b0;
`ifdef DIGIT_SCAN_DEADTIME_EN
    w_gcnt_d  = r_gcnt;
`endif
    if (!en) begin
      w_state_d = StIdle;
      w_idx_d   = '0;
      w_presc_d = '0;
`ifdef DIGIT_SCAN_DEADTIME_EN
      w_gcnt_d  = '0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          w_state_d = StDrive;
          w_idx_d   = '0;
          w_presc_d = '0;
          w_frame_d = 1'b1;
        end
        StDrive: begin
          if (r_presc == PrescLast) begin
            w_presc_d = '0;
`ifdef DIGIT_SCAN_DEADTIME_EN
            w_state_d = StGuard;
            w_gcnt_d  = '0;
`else
            w_idx_d   = w_idx_next;
            w_frame_d = (w_idx_next == '0);
`endif
          end else begin
            w_presc_d = r_presc + 1'b1;
          end
        end
`ifdef DIGIT_SCAN_DEADTIME_EN
        StGuard: begin
          if (r_gcnt == GuardLast) begin
            w_gcnt_d  = '0;
            w_state_d = StDrive;
            w_idx_d   = w_idx_next;
            w_frame_d = (w_idx_next == '0);
          end else begin
            w_gcnt_d  = r_gcnt + 1'b1;
          end
        end
`endif
        default: begin
          w_state_d = StIdle;
          w_idx_d   = '0;
          w_presc_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from next-state so an, sel and frame_start land in the same cycle.
  assign w_drive_on = (w_state_d == StDrive) && !blank_mask[w_idx_d];

  onehot_n_dec #(
    .N(N_DIGITS),
    .W(SEL_W)
  ) u_dec (
    .i_idx (w_idx_d),
    .i_en  (w_drive_on),
    .o_an_n(w_an_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_presc <= '0;
      r_an    <= '1;
      r_sel   <= '0;
      r_frame <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_presc <= w_presc_d;
      r_an    <= w_an_d;
      r_sel   <= w_idx_d;
      r_frame <= w_frame_d;
    end
  end

`ifdef DIGIT_SCAN_DEADTIME_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gcnt <= '0;
    end else begin
      r_gcnt <= w_gcnt_d;
    end
  end
`endif

  assign an          = r_an;
  assign sel         = r_sel;
  assign frame_start = r_frame;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench: two scanner instances compared against a position-based scan model.
module tb_digit_scan_ctrl;

  localparam int NA    = 4;
  localparam int DIV_A = 3;
  localparam int GC    = 2;
  localparam int NB    = 5;
  localparam int DIV_B = 2;
`ifdef DIGIT_SCAN_DEADTIME_EN
  localparam int GM = GC;
`else
  localparam int GM = 0;
`endif
  localparam int PER_A = DIV_A + GM;
  localparam int PER_B = DIV_B + GM;

  logic          clk = 1'b0;
  logic          rst_a, en_a, rst_b, en_b;
  logic [NA-1:0] mask_a, an_a;
  logic [NB-1:0] mask_b, an_b;
  logic [1:0]    sel_a;
  logic [2:0]    sel_b;
  logic          fs_a, fs_b;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  run_a = 0, run_b = 0;
  int  p_a = 0, p_b = 0;
  int  frames_a, blank_cnt, wraps_b;
  bit  found;

  always #5 clk = ~clk;

  digit_scan_ctrl #(.N_DIGITS(NA), .DIV(DIV_A), .GUARD_CYC(GC)) u_dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .blank_mask(mask_a),
    .an(an_a), .sel(sel_a), .frame_start(fs_a)
  );

  digit_scan_ctrl #(.N_DIGITS(NB), .DIV(DIV_B), .GUARD_CYC(GC)) u_dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .blank_mask(mask_b),
    .an(an_b), .sel(sel_b), .frame_start(fs_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, want, $time);
    end
  endtask

  // Position p counts cycles since the scan (re)started; each digit owns div+g cycles.
  function automatic void model(input int n, input int div, input int g, input bit run,
                                input int p, input logic [15:0] mask,
                                output int an_e, output int sel_e, output int fs_e);
    int per, dig, off, all;
    all   = (1 << n) - 1;
    an_e  = all;
    sel_e = 0;
    fs_e  = 0;
    if (run) begin
      per   = div + g;
      dig   = (p / per) % n;
      off   = p % per;
      sel_e = dig;
      if (off < div && !mask[dig]) an_e = all & ~(1 << dig);
      fs_e  = (off == 0 && dig == 0) ? 1 : 0;
    end
  endfunction

  function automatic int zeros(input logic [15:0] v, input int n);
    int z = 0;
    for (int i = 0; i < n; i++) if (!v[i]) z++;
    return z;
  endfunction

  task automatic tick();
    int ea, sa, fa, eb, sb, fb;
    logic [2:0] prev_sel_b;
    prev_sel_b = sel_b;
    @(posedge clk);
    #1;
    if (rst_a || !en_a) run_a = 0;
    else if (!run_a) begin run_a = 1; p_a = 0; end
    else p_a++;
    if (rst_b || !en_b) run_b = 0;
    else if (!run_b) begin run_b = 1; p_b = 0; end
    else p_b++;
    model(NA, DIV_A, GM, run_a, p_a, {12'b0, mask_a}, ea, sa, fa);
    model(NB, DIV_B, GM, run_b, p_b, {11'b0, mask_b}, eb, sb, fb);
    check_eq("a_an", 32'(an_a), 32'(ea));
    check_eq("a_sel", 32'(sel_a), 32'(sa));
    check_eq("a_frame", 32'(fs_a), 32'(fa));
    check_eq("b_an", 32'(an_b), 32'(eb));
    check_eq("b_sel", 32'(sel_b), 32'(sb));
    check_eq("b_frame", 32'(fs_b), 32'(fb));
    check_eq("a_onehot", 32'(zeros({12'b0, an_a}, NA) <= 1), 32'd1);
    check_eq("b_onehot", 32'(zeros({11'b0, an_b}, NB) <= 1), 32'd1);
    if (fs_a) frames_a++;
    if (sel_a == 2'd2 && an_a == 4'hF) blank_cnt++;
    if (prev_sel_b == 3'd4 && sel_b == 3'd0) wraps_b++;
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b1; mask_a = '0;
    rst_b = 1'b1; en_b = 1'b1; mask_b = '0;
    frames_a = 0; blank_cnt = 0; wraps_b = 0;

    // Reset held with en high: outputs stay off.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rst_an", 32'(an_a), 32'hF);
      check_eq("rst_sel", 32'(sel_a), 32'd0);
      check_eq("rst_frame", 32'(fs_a), 32'd0);
    end

    // Plain scan: two full frames from the first DRIVE cycle.
    rst_a = 1'b0; rst_b = 1'b0;
    frames_a = 0;
    tick();
    check_eq("first_an", 32'(an_a), 32'hE);
    check_eq("first_frame", 32'(fs_a), 32'd1);
    for (int i = 1; i < 2 * NA * PER_A; i++) tick();
    check_eq("frame_count", 32'(frames_a), 32'd2);

    // Blanking digit 2 over exactly one pattern period.
    mask_a = 4'b0100;
    blank_cnt = 0;
    for (int i = 0; i < NA * PER_A; i++) tick();
    check_eq("blank_cnt", 32'(blank_cnt), 32'(PER_A));
    mask_a = '0;

    // Drop en in the 2nd cycle of digit 1, then restore it.
    found = 0;
    for (int i = 0; i < 4 * NA * PER_A && !found; i++) begin
      tick();
      if (run_a && ((p_a / PER_A) % NA) == 1 && (p_a % PER_A) == 1) found = 1;
    end
    check_eq("dis_found", 32'(found), 32'd1);
    en_a = 1'b0;
    tick();
    check_eq("dis_an", 32'(an_a), 32'hF);
    check_eq("dis_sel", 32'(sel_a), 32'd0);
    en_a = 1'b1;
    tick();
    check_eq("restart_an", 32'(an_a), 32'hE);
    check_eq("restart_frame", 32'(fs_a), 32'd1);

    // Instance B has been scanning since reset release; it must have wrapped 4 -> 0.
    for (int i = 0; i < 100; i++) tick();
    check_eq("b_wrapped", 32'(wraps_b > 0), 32'd1);

    // Randomised en / mask / reset traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      rst_a = ($urandom_range(99) == 0);
      en_a  = ($urandom_range(29) != 0);
      if ($urandom_range(9) == 0) mask_a = 4'($urandom);
      rst_b = ($urandom_range(99) == 0);
      en_b  = ($urandom_range(29) != 0);
      if ($urandom_range(9) == 0) mask_b = 5'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
